// File: rtl/divider_if.sv
// Operand/result handshake bundle for the iterative divider.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds valid (and its data)
// until that edge, and the sink may raise or drop ready at any time.
interface divider_if #(
   parameter int DIVIDEND_WIDTH = 32,
   parameter int DIVISOR_WIDTH  = 16
);
   logic                      valid_i;
   logic                      ready_o;
   logic [DIVIDEND_WIDTH-1:0] dividend_i;
   logic [DIVISOR_WIDTH-1:0]  divisor_i;
   logic                      valid_o;
   logic                      ready_i;
   logic [DIVIDEND_WIDTH-1:0] quotient_o;
   logic [DIVISOR_WIDTH-1:0]  remainder_o;
   logic                      div_by_zero_o;

   modport slave (
      input  valid_i, dividend_i, divisor_i, ready_i,
      output ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
   );

   modport master (
      output valid_i, dividend_i, divisor_i, ready_i,
      input  ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
   );
endinterface

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Optional signed mode: define DIVIDER_SIGNED_DIV_EN to accept two's
// complement operands (truncating division, remainder follows dividend sign).
// dbg_state_o exposes the FSM state: 0 IDLE, 1 RUN, 2 DONE, 3 FIX.
module divider #(
   parameter int DIVIDEND_WIDTH = 32,
   parameter int DIVISOR_WIDTH  = 16
) (
   input  logic       clk,
   input  logic       rst,
   divider_if.slave   bus,
   output logic [1:0] dbg_state_o
);
   localparam int DW = DIVIDEND_WIDTH;
   localparam int SW = DIVISOR_WIDTH;
   localparam int CW = (DW > 2) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
`ifdef DIVIDER_SIGNED_DIV_EN
      , S_FIX = 2'd3
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   work_q;      // dividend bits shifting out, quotient bits shifting in
   logic [SW-1:0]   dsr_q;       // divisor (magnitude in signed mode)
   logic [SW-1:0]   prem_q;      // partial remainder, always < dsr_q between steps
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   quo_q;
   logic [SW-1:0]   rem_q;
   logic            dbz_q;

   logic            accept;
   logic            div_zero;
   logic [SW:0]     shifted;
   logic [SW:0]     trial;
   logic            take;
   logic [SW-1:0]   prem_nxt;
   logic [DW-1:0]   work_nxt;
   logic [DW-1:0]   dvd_load;
   logic [SW-1:0]   dsr_load;

`ifdef DIVIDER_SIGNED_DIV_EN
   logic            neg_quo_q;   // operand signs differ
   logic            neg_rem_q;   // dividend negative
   // Magnitudes; the most-negative value maps onto itself, which reads
   // correctly as an unsigned magnitude.
   assign dvd_load = bus.dividend_i[DW-1] ? -bus.dividend_i : bus.dividend_i;
   assign dsr_load = bus.divisor_i[SW-1]  ? -bus.divisor_i  : bus.divisor_i;
`else
   assign dvd_load = bus.dividend_i;
   assign dsr_load = bus.divisor_i;
`endif

   assign accept   = bus.valid_i && (state_q == S_IDLE);
   assign div_zero = (bus.divisor_i == '0);

   // One restoring step: the SW+1 bit trial subtract can never overflow.
   always_comb begin
      shifted  = {prem_q, work_q[DW-1]};
      trial    = shifted - {1'b0, dsr_q};
      take     = ~trial[SW];
      prem_nxt = take ? trial[SW-1:0] : shifted[SW-1:0];
      work_nxt = {work_q[DW-2:0], take};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = div_zero ? S_DONE : S_RUN;
`ifdef DIVIDER_SIGNED_DIV_EN
         S_RUN:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
`else
         S_RUN:  if (cnt_q == '0) state_d = S_DONE;
`endif
         S_DONE: if (bus.ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, result capture and sign fix-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         dsr_q  <= '0;
         prem_q <= '0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_DIV_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  work_q <= dvd_load;
                  dsr_q  <= dsr_load;
                  prem_q <= '0;
                  cnt_q  <= CW'(DW - 1);
`ifdef DIVIDER_SIGNED_DIV_EN
                  neg_quo_q <= bus.dividend_i[DW-1] ^ bus.divisor_i[SW-1];
                  neg_rem_q <= bus.dividend_i[DW-1];
`endif
                  if (div_zero) begin
                     quo_q <= '1;
                     rem_q <= bus.dividend_i[SW-1:0];
                     dbz_q <= 1'b1;
                  end else begin
                     dbz_q <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               work_q <= work_nxt;
               prem_q <= prem_nxt;
               if (cnt_q == '0) begin
                  quo_q <= work_nxt;
                  rem_q <= prem_nxt;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
`ifdef DIVIDER_SIGNED_DIV_EN
            S_FIX: begin
               if (neg_quo_q) quo_q <= -quo_q;
               if (neg_rem_q) rem_q <= -rem_q;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.ready_o       = (state_q == S_IDLE);
   assign bus.valid_o       = (state_q == S_DONE);
   assign bus.quotient_o    = quo_q;
   assign bus.remainder_o   = rem_q;
   assign bus.div_by_zero_o = dbz_q;
   assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_divider.sv
// Bench for the iterative divider: directed cases, backpressure, mid-run
// reset and random operands, results matched through an expected queue.
module tb_divider;
   localparam int DW = 32;
   localparam int SW = 16;
   localparam int RW = 1 + DW + SW;
`ifdef DIVIDER_SIGNED_DIV_EN
   localparam int LAT = DW + 2;
`else
   localparam int LAT = DW + 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();

   divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {div_by_zero, quotient, remainder} from plain integer math.
   function automatic logic [RW-1:0] model(input logic [DW-1:0] a, input logic [SW-1:0] b);
      longint la, lb, lq, lr;
      if (b == '0) return {1'b1, {DW{1'b1}}, a[SW-1:0]};
`ifdef DIVIDER_SIGNED_DIV_EN
      la = longint'($signed(a));
      lb = longint'($signed(b));
`else
      la = longint'(a);
      lb = longint'(b);
`endif
      lq = la / lb;
      lr = la % lb;
      return {1'b0, lq[DW-1:0], lr[SW-1:0]};
   endfunction

   function automatic logic [RW-1:0] result();
      return {bus.div_by_zero_o, bus.quotient_o, bus.remainder_o};
   endfunction

   // Driver: issue one division, time it, optionally stall in DONE, retire it.
   task automatic do_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input int stall);
      int n;
      logic busy_ok, hold_ok;
      logic [RW-1:0] snap, exp;
      check_val("ready_in_idle", 64'(bus.ready_o), 64'(1));
      bus.valid_i    = 1'b1;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      bus.ready_i    = 1'b0;
      @(posedge clk); #1;
      bus.valid_i    = 1'b0;
      bus.dividend_i = $urandom;
      bus.divisor_i  = SW'($urandom);
      exp_q.push_back(model(a, b));
      n = 1;
      busy_ok = 1'b1;
      while (!bus.valid_o && n < 200) begin
         if (bus.ready_o) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      check_val("busy_ready_low", 64'(busy_ok), 64'(1));
      check_val("latency", 64'(n), 64'((b == '0) ? 1 : LAT));
      snap = result();
      hold_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
         bus.valid_i    = 1'($urandom_range(0, 1));
         bus.dividend_i = $urandom;
         bus.divisor_i  = SW'($urandom);
         @(posedge clk); #1;
         if (result() !== snap || bus.ready_o || !bus.valid_o || dbg_state != 2'd2) hold_ok = 1'b0;
      end
      if (stall > 0) check_val("hold_stable", 64'(hold_ok), 64'(1));
      exp = exp_q.pop_front();
      check_val("result", 64'(snap), 64'(exp));
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      check_val("retire_valid_low", 64'(bus.valid_o), 64'(0));
      check_val("retire_ready_high", 64'(bus.ready_o), 64'(1));
      check_val("retire_state_idle", 64'(dbg_state), 64'(0));
      check_val("retire_keeps_result", 64'(result()), 64'(exp));
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_ready"}, 64'(bus.ready_o), 64'(1));
      check_val({tag, "_valid"}, 64'(bus.valid_o), 64'(0));
      check_val({tag, "_quotient"}, 64'(bus.quotient_o), 64'(0));
      check_val({tag, "_remainder"}, 64'(bus.remainder_o), 64'(0));
      check_val({tag, "_dbz"}, 64'(bus.div_by_zero_o), 64'(0));
      check_val({tag, "_state"}, 64'(dbg_state), 64'(0));
   endtask

   // Stimulus sequence and final report.
   initial begin
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      rst            = 1'b1;
      bus.valid_i    = 1'b0;
      bus.ready_i    = 1'b0;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(32'd100, 16'd7, 0);
      do_op(32'hFFFF_FFFF, 16'd1, 0);
      do_op(32'h0000_FFFE, 16'hFFFF, 0);
      do_op(32'd5, 16'd0, 0);
      do_op(32'd9, 16'd3, 0);
      do_op(32'd1234567, 16'd89, 10);

      // Abort a division 12 edges into RUN.
      bus.valid_i    = 1'b1;
      bus.dividend_i = 32'd1000;
      bus.divisor_i  = 16'd3;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_val("mid_run_state", 64'(dbg_state), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_values("mid_reset");
      do_op(32'd50, 16'd5, 0);

`ifdef DIVIDER_SIGNED_DIV_EN
      do_op(-32'sd7, 16'd2, 0);
      do_op(32'd7, -16'sd2, 0);
      do_op(32'h8000_0000, 16'hFFFF, 0);
      do_op(-32'sd100, -16'sd7, 0);
`endif

      for (int k = 0; k < 20; k++) begin
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom_range(1, 65535));
         if (k % 4 == 0) a = a >> $urandom_range(0, 31);
         do_op(a, b, int'($urandom_range(0, 3)));
      end

      check_val("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
